// File: rtl/sel_token_issuer_pkg.sv
// Shared types for the select-token issuer: FSM state encoding and select width.
package sel_issue_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StDrive,
    StWait
  } state_e;

endpackage

// File: rtl/sel_token_issuer_if.sv
// Command handshake into the issuer: valid/ready with a branch-select payload.
interface sel_token_issuer_if;
  import sel_issue_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;

  modport master (output cmd_valid, output cmd_sel, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_sel, output cmd_ready);

endinterface

// File: rtl/sel_token_issuer_cmd_fifo.sv
// Power-of-two synchronous FIFO with asynchronous active-high reset and occupancy count.
module cmd_fifo
  import sel_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = SEL_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only read when the count says it holds data.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sel_token_issuer.sv
// Clocked token source for a two-way conditional split: queues selects, drives one token at a
// time and waits for the split's asynchronous free pulse before issuing the next.
module sel_token_issuer
  import sel_issue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DRIVE_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  sel_token_issuer_if.slave cmd,
  output logic              o_drive,
  output logic              o_valid0,
  output logic              o_valid1,
  input  logic              i_free,
  input  logic              clr_timeout,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_done_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW-1:0] DrvLast = DW'(DRIVE_CYCLES - 1);
  localparam logic [TW-1:0] ToMax   = TW'(TIMEOUT);

  state_e           state_q, state_d;
  logic [DW-1:0]    drv_cnt_q, drv_cnt_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [SEL_W-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             pend_q, pend_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       sync_q;
  logic             free_edge;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [SEL_W-1:0] fifo_rdata;
  logic [PW:0]      fifo_cnt;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SEL_W)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (cmd.cmd_valid),
    .wdata_i (cmd.cmd_sel),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Two synchronizer flops, third flop only for rising-edge detection.
  assign free_edge = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d    = state_q;
    drv_cnt_d  = drv_cnt_q;
    wait_cnt_d = '0;
    valid_d    = valid_q;
    done_d     = done_q;
    pend_d     = pend_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        pend_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_rdata != '0) begin
            valid_d = fifo_rdata;
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        drv_cnt_d = '0;
        state_d   = StDrive;
        if (free_edge) pend_d = 1'b1;
      end
      StDrive: begin
        if (free_edge) pend_d = 1'b1;
        if (drv_cnt_q == DrvLast) state_d = StWait;
        else                      drv_cnt_d = drv_cnt_q + 1'b1;
      end
      StWait: begin
        if (free_edge || pend_q) begin
          valid_d = '0;
          pend_d  = 1'b0;
          done_d  = done_q + 1'b1;
          state_d = StIdle;
        end else begin
          wait_cnt_d = (wait_cnt_q == ToMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set beats clear when the counter still sits at the limit.
  always_comb begin
    timeout_d = timeout_q & ~clr_timeout;
    if ((TIMEOUT != 0) && (state_q == StWait) && (wait_cnt_q == ToMax)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      drv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      pend_q     <= 1'b0;
      timeout_q  <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      drv_cnt_q  <= drv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      timeout_q  <= timeout_d;
      sync_q     <= {sync_q[1:0], i_free};
    end
  end

  assign cmd.cmd_ready = !fifo_full;
  assign o_drive       = (state_q == StDrive);
  assign o_valid0      = valid_q[0];
  assign o_valid1      = valid_q[1];
  assign o_busy        = (state_q != StIdle) | (fifo_cnt != '0);
  assign o_timeout     = timeout_q;
  assign o_done_cnt    = done_q;

endmodule

// File: tb/tb_sel_token_issuer.sv
// Directed bench for sel_token_issuer with a select scoreboard and a bench-side free responder.
module tb_sel_token_issuer;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned DRIVE_CYCLES = 4;
  localparam int unsigned TIMEOUT      = 8;
  localparam int unsigned CNT_W        = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             o_drive, o_valid0, o_valid1;
  logic             i_free;
  logic             clr_timeout;
  logic             o_busy, o_timeout;
  logic [CNT_W-1:0] o_done_cnt;

  sel_token_issuer_if cmd_if ();

  sel_token_issuer #(
    .DEPTH        (DEPTH),
    .DRIVE_CYCLES (DRIVE_CYCLES),
    .TIMEOUT      (TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .o_drive     (o_drive),
    .o_valid0    (o_valid0),
    .o_valid1    (o_valid1),
    .i_free      (i_free),
    .clr_timeout (clr_timeout),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout),
    .o_done_cnt  (o_done_cnt)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         exp_done = 0;
  logic [1:0] sb_q [$];
  logic [1:0] cur_sel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel);
    int k = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_sel   = sel;
    while (cmd_if.cmd_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) chk("push_ready_wait", {31'b0, cmd_if.cmd_ready}, 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    if (sel != 2'b00) sb_q.push_back(sel);
  endtask

  task automatic take_token();
    int k = 0;
    while (o_drive !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("drive_rise", {31'b0, o_drive}, 32'd1);
    chk("sb_nonempty", {31'b0, sb_q.size() > 0}, 32'd1);
    cur_sel = (sb_q.size() > 0) ? sb_q.pop_front() : 2'b00;
    chk("token_sel", {30'b0, o_valid1, o_valid0}, {30'b0, cur_sel});
  endtask

  task automatic finish_token(input int free_delay);
    int k = 0;
    while (o_drive !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk("drive_fall", {31'b0, o_drive}, 32'd0);
    chk("hold_sel", {30'b0, o_valid1, o_valid0}, {30'b0, cur_sel});
    repeat (free_delay) tick();
    i_free = 1'b1;
    tick();
    tick();
    i_free = 1'b0;
    k = 0;
    while ({o_valid1, o_valid0} !== 2'b00 && k < 10) begin
      tick();
      k++;
    end
    chk("release", {30'b0, o_valid1, o_valid0}, 32'd0);
    exp_done++;
    chk("done_cnt", {28'b0, o_done_cnt}, exp_done % 16);
  endtask

  initial begin
    rst              = 1'b1;
    i_free           = 1'b0;
    clr_timeout      = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_sel   = 2'b00;
    repeat (3) tick();
    chk("rst_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_drive", {31'b0, o_drive}, 32'd0);
    chk("rst_valids", {30'b0, o_valid1, o_valid0}, 32'd0);
    chk("rst_timeout", {31'b0, o_timeout}, 32'd0);
    chk("rst_done", {28'b0, o_done_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Single token with exact cycle placement.
    push(2'b01);
    chk("t1_e0_valids", {30'b0, o_valid1, o_valid0}, 32'd0);
    chk("t1_e0_busy", {31'b0, o_busy}, 32'd1);
    tick();
    cur_sel = sb_q.pop_front();
    chk("t1_e1_valids", {30'b0, o_valid1, o_valid0}, {30'b0, cur_sel});
    chk("t1_e1_drive", {31'b0, o_drive}, 32'd0);
    for (int i = 0; i < DRIVE_CYCLES; i++) begin
      tick();
      chk("t1_drive_hi", {31'b0, o_drive}, 32'd1);
    end
    tick();
    chk("t1_drive_lo", {31'b0, o_drive}, 32'd0);
    finish_token(3);
    chk("t1_busy_after", {31'b0, o_busy}, 32'd0);

    // Back-to-back pushes fill the FIFO behind an in-flight token; 00 is discarded.
    push(2'b11);
    push(2'b10);
    push(2'b00);
    push(2'b01);
    push(2'b10);
    chk("t2_full_ready", {31'b0, cmd_if.cmd_ready}, 32'd0);
    chk("t2_busy", {31'b0, o_busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      take_token();
      finish_token(1);
    end
    repeat (4) tick();
    chk("t2_idle_busy", {31'b0, o_busy}, 32'd0);
    chk("t2_sb_drained", sb_q.size(), 32'd0);

    // Free pulse arrives during SETUP/DRIVE: first WAIT cycle completes.
    push(2'b01);
    tick();
    cur_sel = sb_q.pop_front();
    chk("t3_valids", {30'b0, o_valid1, o_valid0}, {30'b0, cur_sel});
    i_free = 1'b1;
    tick();
    chk("t3_drive_e2", {31'b0, o_drive}, 32'd1);
    tick();
    i_free = 1'b0;
    tick();
    tick();
    chk("t3_drive_e5", {31'b0, o_drive}, 32'd1);
    tick();
    chk("t3_wait_drive", {31'b0, o_drive}, 32'd0);
    chk("t3_wait_hold", {30'b0, o_valid1, o_valid0}, {30'b0, cur_sel});
    tick();
    chk("t3_exit_valids", {30'b0, o_valid1, o_valid0}, 32'd0);
    exp_done++;
    chk("t3_done", {28'b0, o_done_cnt}, exp_done % 16);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_no_redrive", {31'b0, o_drive}, 32'd0);
    end
    chk("t3_busy", {31'b0, o_busy}, 32'd0);

    // No free: timeout sets, token held, late free completes, clear drops flag.
    push(2'b10);
    take_token();
    while (o_drive !== 1'b0) tick();
    chk("t4_to_early", {31'b0, o_timeout}, 32'd0);
    repeat (TIMEOUT + 4) tick();
    chk("t4_to_set", {31'b0, o_timeout}, 32'd1);
    chk("t4_hold_v1", {31'b0, o_valid1}, 32'd1);
    chk("t4_hold_v0", {31'b0, o_valid0}, 32'd0);
    chk("t4_busy", {31'b0, o_busy}, 32'd1);
    finish_token(0);
    tick();
    chk("t4_to_sticky", {31'b0, o_timeout}, 32'd1);
    clr_timeout = 1'b1;
    tick();
    clr_timeout = 1'b0;
    chk("t4_to_clr", {31'b0, o_timeout}, 32'd0);

    // Asynchronous reset mid-DRIVE with two commands queued.
    push(2'b01);
    push(2'b10);
    push(2'b11);
    take_token();
    rst = 1'b1;
    #1;
    chk("t5_drive", {31'b0, o_drive}, 32'd0);
    chk("t5_valids", {30'b0, o_valid1, o_valid0}, 32'd0);
    chk("t5_busy", {31'b0, o_busy}, 32'd0);
    chk("t5_done", {28'b0, o_done_cnt}, 32'd0);
    sb_q.delete();
    exp_done = 0;
    #2;
    rst = 1'b0;
    tick();
    chk("t5_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    chk("t5_empty", {31'b0, o_busy}, 32'd0);
    repeat (5) tick();
    chk("t5_no_token", {31'b0, o_drive}, 32'd0);

    // Counter wrap: 17 tokens on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      push(2'((i % 3) + 1));
      take_token();
      finish_token(i % 2);
    end
    chk("t6_wrap", {28'b0, o_done_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
